multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; sits directly upstream of the ALU control decoder and drives its 2-bit alu_op.
- Decodes the 6-bit instruction opcode and sequences fetch, decode, execute, memory and writeback.
- Produces all datapath mux selects and write enables, and the PC enable.
- Stalls on a single-port memory request/ready handshake.

Parameters:
- none (opcode set fixed: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instr[31:26] from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- mem_req  output  1  memory access request
- mem_write  output  1  write strobe, qualified by mem_req
- iord  output  1  address select: 0 = PC, 1 = ALU out
- ir_write  output  1  load instruction register
- reg_write  output  1  register file write enable
- reg_dst  output  1  0 = rt, 1 = rd
- mem_to_reg  output  1  0 = ALU out, 1 = data register
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
- alu_op  output  2  00 = add, 01 = subtract, 10 = use funct field; goes to the ALU control decoder
- pc_src  output  2  00 = ALU result, 01 = ALU out, 10 = jump target
- pc_en  output  1  PC register enable
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- instr_done  output  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset and state register:
  - rst_n low asynchronously forces state IDLE.
  - In IDLE every output is 0.
  - IDLE always advances to FETCH on the next edge.
- Outputs are Moore-decoded from state; exceptions are noted per state. Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_en equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - Next state by opcode: lw/sw -> MEMADR, R-type -> RTYPEEX, beq -> BEQEX, addi -> ADDIEX, j -> JEX, any other -> ILLEGAL.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Hold while mem_ready=0, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next state FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Hold while mem_ready=0. When mem_ready=1, instr_done=1 and next state FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10. Next state RTYPEWB.
- RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BEQEX:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_en = zero (Mealy).
  - instr_done=1. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- JEX: pc_src=10, pc_en=1, instr_done=1. Next state FETCH.
- ILLEGAL: illegal_op=1, no writes. Next state FETCH.
- Cycle counts with zero-wait memory:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state without mem_req.
- opcode is sampled only in DECODE and MEMADR; it is stable there because ir_write=0.
- Reset asserted mid-instruction: immediate return to IDLE with outputs 0; no partial register or memory write may complete after rst_n falls.
- State encoding is implementation choice; no unreachable state may lock up; any undefined encoding returns to IDLE.

Test Plan:
- Reset release, mem_ready=1, opcode=000000 -> IDLE 1 cycle (all outputs 0), then FETCH with ir_write=1, pc_en=1, alu_src_b=01; RTYPEEX shows alu_op=10; RTYPEWB shows reg_write=1, reg_dst=1; instr_done on cycle 4 after FETCH entry.
- lw (100011) with mem_ready low 2 cycles in FETCH and 1 in MEMRD -> FETCH held 3 cycles, ir_write only on the ready cycle; MEMRD held 2 cycles with iord=1; MEMWB has mem_to_reg=1; total 8 cycles.
- sw (101011), mem_ready=1 -> MEMWR has mem_write=1, iord=1; reg_write never 1; instr_done in cycle 4.
- beq with zero=1, then beq with zero=0 -> BEQEX: alu_op=01, pc_src=01; pc_en=1 and 0 respectively.
- j (000010), then opcode 111111 -> JEX: pc_src=10, pc_en=1; ILLEGAL: illegal_op pulses 1 cycle, no reg_write or mem_write, next state FETCH.
- rst_n dropped during MEMWR while mem_ready=0 -> mem_req and mem_write drop to 0 asynchronously; after release, sequence restarts at IDLE then FETCH.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// master: the control FSM (consumes opcode/zero/mem_ready, drives all selects/enables)
// slave : the datapath and memory side (drives opcode/zero/mem_ready, consumes controls)
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;
    logic       instr_done;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, instr_done
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, instr_done
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, stalls on the single-port
// memory handshake, and decodes every datapath select/enable from state.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (state forced to IDLE)
//   bus   - master side of multicycle_control_if (opcode, zero, mem_ready in;
//           memory request, mux selects, write enables, alu_op, status pulses out)
// Control outputs are decoded from state (plus mem_ready in FETCH and zero in
// BEQEX), so they fall to 0 as soon as rst_n is asserted.
module multicycle_control (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        bus
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JEX     = 4'd12,
        S_ILLEGAL = 4'd13
    } state_e;

    state_e state_q, state_d;

    logic       mem_req_c;
    logic       mem_write_c;
    logic       iord_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       reg_dst_c;
    logic       mem_to_reg_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic [1:0] pc_src_c;
    logic       pc_en_c;
    logic       illegal_op_c;
    logic       instr_done_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d      = S_IDLE;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        iord_c       = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        pc_src_c     = 2'b00;
        pc_en_c      = 1'b0;
        illegal_op_c = 1'b0;
        instr_done_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC + 4 computed while the instruction is read
                mem_req_c   = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = bus.mem_ready;
                pc_en_c     = bus.mem_ready;
                state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALU out
                alu_src_b_c = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                state_d   = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c    = 1'b1;
                mem_write_c  = 1'b1;
                iord_c       = 1'b1;
                instr_done_c = bus.mem_ready;
                state_d      = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                state_d     = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQEX: begin
                // Branch taken only when the compare subtract is zero
                alu_src_a_c  = 1'b1;
                alu_op_c     = 2'b01;
                pc_src_c     = 2'b01;
                pc_en_c      = bus.zero;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JEX: begin
                pc_src_c     = 2'b10;
                pc_en_c      = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_op_c = 1'b1;
                state_d      = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mem_req    = mem_req_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.iord       = iord_c;
    assign bus.ir_write   = ir_write_c;
    assign bus.reg_write  = reg_write_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.pc_src     = pc_src_c;
    assign bus.pc_en      = pc_en_c;
    assign bus.illegal_op = illegal_op_c;
    assign bus.instr_done = instr_done_c;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected
// output sequences are generated from the instruction type and wait counts,
// then replayed cycle by cycle against the DUT.
module tb_multicycle_control;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        logic        rdy;
        logic        z;
        logic [16:0] exp;
    } step_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         fw;
        int         mw;
        int         cycles;
        int         n_regw;
        int         n_memw;
        int         n_pcen;
        int         n_ill;
    } vec_t;

    step_t plan[$];
    int    checks = 0;
    int    errors = 0;

    // Field order: req wr iord irw regw rdst m2r srca srcb aluop pcsrc pcen ill done
    function automatic logic [16:0] cv(logic req, logic wr, logic iord, logic irw,
                                       logic regw, logic rdst, logic m2r, logic sa,
                                       logic [1:0] sb, logic [1:0] aop, logic [1:0] psrc,
                                       logic pcen, logic ill, logic done);
        return {req, wr, iord, irw, regw, rdst, m2r, sa, sb, aop, psrc, pcen, ill, done};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.reg_write,
                bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_src, bus.pc_en, bus.illegal_op, bus.instr_done};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(logic rdy, logic z, logic [16:0] e);
        step_t s;
        s.rdy = rdy;
        s.z   = z;
        s.exp = e;
        plan.push_back(s);
    endfunction

    // Expected per-cycle control pattern for one instruction
    function automatic void build(logic [5:0] op, logic z, int fw, int mw);
        plan.delete();
        for (int i = 0; i < fw; i++)
            push(1'b0, rb(), cv(1,0,0,0, 0,0,0,0, 2'b01,2'b00,2'b00, 0,0,0));
        push(1'b1, rb(), cv(1,0,0,1, 0,0,0,0, 2'b01,2'b00,2'b00, 1,0,0));
        push(rb(), rb(), cv(0,0,0,0, 0,0,0,0, 2'b11,2'b00,2'b00, 0,0,0));
        case (op)
            OP_LW: begin
                push(rb(), rb(), cv(0,0,0,0, 0,0,0,1, 2'b10,2'b00,2'b00, 0,0,0));
                for (int i = 0; i < mw; i++)
                    push(1'b0, rb(), cv(1,0,1,0, 0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0));
                push(1'b1, rb(), cv(1,0,1,0, 0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0));
                push(rb(), rb(), cv(0,0,0,0, 1,0,1,0, 2'b00,2'b00,2'b00, 0,0,1));
            end
            OP_SW: begin
                push(rb(), rb(), cv(0,0,0,0, 0,0,0,1, 2'b10,2'b00,2'b00, 0,0,0));
                for (int i = 0; i < mw; i++)
                    push(1'b0, rb(), cv(1,1,1,0, 0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0));
                push(1'b1, rb(), cv(1,1,1,0, 0,0,0,0, 2'b00,2'b00,2'b00, 0,0,1));
            end
            OP_R: begin
                push(rb(), rb(), cv(0,0,0,0, 0,0,0,1, 2'b00,2'b10,2'b00, 0,0,0));
                push(rb(), rb(), cv(0,0,0,0, 1,1,0,0, 2'b00,2'b00,2'b00, 0,0,1));
            end
            OP_BEQ:
                push(rb(), z, cv(0,0,0,0, 0,0,0,1, 2'b00,2'b01,2'b01, z,0,1));
            OP_ADDI: begin
                push(rb(), rb(), cv(0,0,0,0, 0,0,0,1, 2'b10,2'b00,2'b00, 0,0,0));
                push(rb(), rb(), cv(0,0,0,0, 1,0,0,0, 2'b00,2'b00,2'b00, 0,0,1));
            end
            OP_J:
                push(rb(), rb(), cv(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b10, 1,0,1));
            default:
                push(rb(), rb(), cv(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00, 0,1,0));
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Replay up to 'limit' steps of the plan (limit < 0 => whole plan)
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                             input int limit, output int retire, output int n_regw,
                             output int n_memw, output int n_pcen, output int n_ill);
        int n;
        build(op, z, fw, mw);
        n = (limit < 0) ? plan.size() : limit;
        retire = 0; n_regw = 0; n_memw = 0; n_pcen = 0; n_ill = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.opcode    = op;
            bus.mem_ready = plan[i].rdy;
            bus.zero      = plan[i].z;
            #1;
            chk($sformatf("op%b_step%0d", op, i), 32'(dut_vec()), 32'(plan[i].exp));
            if (bus.reg_write) n_regw++;
            if (bus.mem_write && bus.mem_req) n_memw++;
            if (bus.pc_en) n_pcen++;
            if (bus.illegal_op) n_ill++;
            if ((bus.instr_done || bus.illegal_op) && retire == 0) retire = i + 1;
        end
    endtask

    task automatic check_totals(input vec_t v, input int ret, input int rw, input int mw,
                                input int pe, input int il);
        chk($sformatf("op%b_cycles", v.op), 32'(ret), 32'(v.cycles));
        chk($sformatf("op%b_regw", v.op),   32'(rw),  32'(v.n_regw));
        chk($sformatf("op%b_memw", v.op),   32'(mw),  32'(v.n_memw));
        chk($sformatf("op%b_pcen", v.op),   32'(pe),  32'(v.n_pcen));
        chk($sformatf("op%b_ill", v.op),    32'(il),  32'(v.n_ill));
    endtask

    function automatic int base_cycles(logic [5:0] op);
        case (op)
            OP_LW:                 return 5;
            OP_SW, OP_R, OP_ADDI:  return 4;
            default:               return 3;
        endcase
    endfunction

    initial begin
        vec_t vecs[10];
        logic [5:0] pool[7];
        int ret, rw, mwc, pe, il;

        vecs[0] = '{OP_R,    1'b0, 0, 0, 4, 1, 0, 1, 0};
        vecs[1] = '{OP_LW,   1'b0, 2, 1, 8, 1, 0, 1, 0};
        vecs[2] = '{OP_SW,   1'b0, 0, 0, 4, 0, 1, 1, 0};
        vecs[3] = '{OP_BEQ,  1'b1, 0, 0, 3, 0, 0, 2, 0};
        vecs[4] = '{OP_BEQ,  1'b0, 0, 0, 3, 0, 0, 1, 0};
        vecs[5] = '{OP_J,    1'b0, 0, 0, 3, 0, 0, 2, 0};
        vecs[6] = '{OP_BAD,  1'b0, 0, 0, 3, 0, 0, 1, 1};
        vecs[7] = '{OP_ADDI, 1'b0, 1, 0, 5, 1, 0, 1, 0};
        vecs[8] = '{OP_SW,   1'b0, 0, 2, 6, 0, 3, 1, 0};
        vecs[9] = '{OP_LW,   1'b0, 0, 0, 5, 1, 0, 1, 0};

        pool = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, 6'b001101};

        bus.opcode    = OP_R;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        // Reset held: all outputs quiet
        #1;
        chk("reset_outputs", 32'(dut_vec()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_outputs", 32'(dut_vec()), 32'd0);

        // Directed instruction table
        foreach (vecs[k]) begin
            run_instr(vecs[k].op, vecs[k].z, vecs[k].fw, vecs[k].mw, -1, ret, rw, mwc, pe, il);
            check_totals(vecs[k], ret, rw, mwc, pe, il);
        end

        // Reset during a stalled store: outputs drop immediately
        run_instr(OP_SW, 1'b0, 0, 3, 4, ret, rw, mwc, pe, il);
        chk("memwr_req_before_rst", 32'({bus.mem_req, bus.mem_write}), 32'(2'b11));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'(dut_vec()), 32'd0);
        @(negedge clk);
        chk("rst_hold_outputs", 32'(dut_vec()), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_after_rst", 32'(dut_vec()), 32'd0);
        run_instr(OP_R, 1'b0, 0, 0, -1, ret, rw, mwc, pe, il);
        check_totals(vecs[0], ret, rw, mwc, pe, il);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            vec_t v;
            v.op     = pool[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) v.op = OP_BAD;
            v.z      = rb();
            v.fw     = $urandom_range(0, 3);
            v.mw     = $urandom_range(0, 3);
            v.cycles = base_cycles(v.op) + v.fw +
                       (((v.op == OP_LW) || (v.op == OP_SW)) ? v.mw : 0);
            v.n_regw = ((v.op == OP_LW) || (v.op == OP_R) || (v.op == OP_ADDI)) ? 1 : 0;
            v.n_memw = (v.op == OP_SW) ? v.mw + 1 : 0;
            v.n_pcen = 1 + ((v.op == OP_J) ? 1 : 0) + (((v.op == OP_BEQ) && v.z) ? 1 : 0);
            v.n_ill  = ((v.op == OP_LW) || (v.op == OP_SW) || (v.op == OP_R) ||
                        (v.op == OP_BEQ) || (v.op == OP_ADDI) || (v.op == OP_J)) ? 0 : 1;
            run_instr(v.op, v.z, v.fw, v.mw, -1, ret, rw, mwc, pe, il);
            check_totals(v, ret, rw, mwc, pe, il);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
